// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
// Operands are held in registers for EXEC_CYCLES cycles, then f/z are captured and returned.
module alu_share_arbiter #(
  parameter int WIDTH       = 32,
  parameter int SELW        = 5,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [SELW-1:0]  r0_sel,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [SELW-1:0]  r1_sel,
  output logic             r0_rsp_valid,
  input  logic             r0_rsp_ready,
  output logic             r1_rsp_valid,
  input  logic             r1_rsp_ready,
  output logic [WIDTH-1:0] rsp_f,
  output logic             rsp_z,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SELW-1:0]  alu_sel,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             alu_z,
  output logic             busy
);

  generate
    if (EXEC_CYCLES < 1 || EXEC_CYCLES > 15) begin : g_bad_exec_cycles
      $error("alu_share_arbiter: EXEC_CYCLES must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  logic       last_grant;
  logic       id;
  logic [3:0] cnt;
  logic       grant;
  logic       accept;
  logic       rsp_done;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    grant = 1'b0;
    if (r0_valid && r1_valid) grant = ~last_grant;
    else if (r1_valid)        grant = 1'b1;
  end

  assign r0_ready = !rst && (state == IDLE) && !grant && r0_valid;
  assign r1_ready = !rst && (state == IDLE) &&  grant && r1_valid;
  assign accept   = r0_ready || r1_ready;
  assign rsp_done = id ? r1_rsp_ready : r0_rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      id           <= 1'b0;
      cnt          <= 4'd0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_sel      <= '0;
      rsp_f        <= '0;
      rsp_z        <= 1'b0;
      r0_rsp_valid <= 1'b0;
      r1_rsp_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a   <= grant ? r1_a   : r0_a;
            alu_b   <= grant ? r1_b   : r0_b;
            alu_sel <= grant ? r1_sel : r0_sel;
            id      <= grant;
            cnt     <= CNT_INIT;
            busy    <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_f        <= alu_f;
            rsp_z        <= alu_z;
            r0_rsp_valid <= ~id;
            r1_rsp_valid <= id;
            state        <= RESP;
          end
        end
        RESP: begin
          // Only the owner's rsp_ready matters; no new accept until back in IDLE.
          if (rsp_done) begin
            last_grant   <= id;
            r0_rsp_valid <= 1'b0;
            r1_rsp_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  function automatic logic [32:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [4:0] sel);
    logic [31:0] f;
    case (sel)
      5'd0:     f = a + b;
      5'd1:     f = a - b;
      5'd2:     f = a & b;
      5'd3:     f = a | b;
      5'd4:     f = a ^ b;
      5'd5:     f = a << b[4:0];
      5'd6:     f = a >> b[4:0];
      5'd7:     f = $signed(a) >>> b[4:0];
      5'd8:     f = {31'd0, $signed(a) < $signed(b)};
      5'd16:    f = ~a;
      5'd21:    f = b;
      default:  f = a;
    endcase
    return {(f == 32'd0), f};
  endfunction

  // DUT with EXEC_CYCLES=1
  logic        rst, r0_valid, r0_ready, r1_valid, r1_ready;
  logic [31:0] r0_a, r0_b, r1_a, r1_b, rsp_f, alu_a, alu_b, alu_f;
  logic [4:0]  r0_sel, r1_sel, alu_sel;
  logic        r0_rsp_valid, r0_rsp_ready, r1_rsp_valid, r1_rsp_ready, rsp_z, alu_z, busy;

  assign {alu_z, alu_f} = alu_fn(alu_a, alu_b, alu_sel);

  alu_share_arbiter #(.WIDTH(32), .SELW(5), .EXEC_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_sel(r0_sel),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_sel(r1_sel),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
    .rsp_f(rsp_f), .rsp_z(rsp_z),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_f(alu_f), .alu_z(alu_z),
    .busy(busy)
  );

  // DUT with EXEC_CYCLES=3
  logic        c_rst, c_r0_valid, c_r0_ready, c_r1_ready, c_r0_rsp_valid, c_r0_rsp_ready, c_r1_rsp_valid;
  logic        c_rsp_z, c_alu_z, c_busy;
  logic [31:0] c_r0_a, c_r0_b, c_rsp_f, c_alu_a, c_alu_b, c_alu_f;
  logic [4:0]  c_r0_sel, c_alu_sel;

  assign {c_alu_z, c_alu_f} = alu_fn(c_alu_a, c_alu_b, c_alu_sel);

  alu_share_arbiter #(.WIDTH(32), .SELW(5), .EXEC_CYCLES(3)) dut3 (
    .clk(clk), .rst(c_rst),
    .r0_valid(c_r0_valid), .r0_ready(c_r0_ready), .r0_a(c_r0_a), .r0_b(c_r0_b), .r0_sel(c_r0_sel),
    .r1_valid(1'b0), .r1_ready(c_r1_ready), .r1_a(32'd0), .r1_b(32'd0), .r1_sel(5'd0),
    .r0_rsp_valid(c_r0_rsp_valid), .r0_rsp_ready(c_r0_rsp_ready),
    .r1_rsp_valid(c_r1_rsp_valid), .r1_rsp_ready(1'b1),
    .rsp_f(c_rsp_f), .rsp_z(c_rsp_z),
    .alu_a(c_alu_a), .alu_b(c_alu_b), .alu_sel(c_alu_sel), .alu_f(c_alu_f), .alu_z(c_alu_z),
    .busy(c_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Single isolated op on the EXEC_CYCLES=1 DUT; call at a negedge with the DUT idle.
  task automatic run_op(input bit req, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sel, input logic [31:0] ef, input logic ez);
    if (req) begin r1_valid = 1'b1; r1_a = a; r1_b = b; r1_sel = sel; end
    else     begin r0_valid = 1'b1; r0_a = a; r0_b = b; r0_sel = sel; end
    #1;
    check("op_ready", {r0_ready, r1_ready}, req ? 2'b01 : 2'b10);
    tick();
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    #1;
    check("op_exec_no_rsp", {r0_rsp_valid, r1_rsp_valid}, 2'b00);
    check("op_exec_busy", busy, 1'b1);
    tick();
    r0_rsp_ready = 1'b1;
    r1_rsp_ready = 1'b1;
    #1;
    check("op_rsp_valid", {r0_rsp_valid, r1_rsp_valid}, req ? 2'b01 : 2'b10);
    check("op_rsp_f", rsp_f, ef);
    check("op_rsp_z", rsp_z, ez);
    tick();
    r0_rsp_ready = 1'b0;
    r1_rsp_ready = 1'b0;
    #1;
    check("op_idle_after", busy, 1'b0);
  endtask

  typedef struct {
    bit          req;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sel;
    logic [31:0] ef;
    logic        ez;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input bit req, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sel);
    vec_t v;
    logic [32:0] r;
    r = alu_fn(a, b, sel);
    v.req = req; v.a = a; v.b = b; v.sel = sel; v.ef = r[31:0]; v.ez = r[32];
    vecs.push_back(v);
  endtask

  // Transaction-level reference for random traffic
  bit          m_busy, m_owner, m_last, win, e0, e1, acc0, acc1;
  int          m_wait;
  logic [32:0] m_exp;

  initial begin
    logic [31:0] a2;
    logic [31:0] p0, p1;
    logic [32:0] r;

    rst = 1'b1; c_rst = 1'b1;
    r0_valid = 1'b1; r1_valid = 1'b1;
    r0_a = 32'hAAAA5555; r0_b = 32'h1; r0_sel = 5'd0;
    r1_a = 32'h5555AAAA; r1_b = 32'h2; r1_sel = 5'd1;
    r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;
    c_r0_valid = 1'b0; c_r0_a = 32'd0; c_r0_b = 32'd0; c_r0_sel = 5'd0; c_r0_rsp_ready = 1'b0;

    // Reset with both requesters asserting valid
    @(negedge clk);
    tick();
    #1;
    check("rst_ready", {r0_ready, r1_ready}, 2'b00);
    check("rst_rsp_valid", {r0_rsp_valid, r1_rsp_valid}, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_f", rsp_f, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst3_busy", c_busy, 1'b0);
    r0_valid = 1'b0; r1_valid = 1'b0;
    rst = 1'b0; c_rst = 1'b0;
    tick();

    // Table: single-op sel sweep on r0, then zero-flag patterns on alternating requesters
    foreach (vecs[i]) vecs.delete(i);
    for (int s = 0; s < 8; s++) add_vec(1'b0, 32'h0000000F, 32'h00000003, 5'(s));
    add_vec(1'b0, 32'h0000000F, 32'h00000003, 5'b10000);
    add_vec(1'b0, 32'h0000000F, 32'h00000003, 5'b10101);
    add_vec(1'b0, 32'h0000000F, 32'h00000003, 5'b01000);
    for (int s = 0; s < 32; s++) begin
      add_vec(s[0], 32'h00000000, 32'h00000000, 5'(s));
      add_vec(~s[0], 32'hFFFFFFFF, 32'hFFFFFFFF, 5'(s));
    end
    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].ef, vecs[i].ez);

    // Contention: both valid continuously, expect r0, r1, r0, r1
    reset_dut();
    p0 = 32'h00000005; p1 = 32'h01234567;
    r0_valid = 1'b1; r0_a = p0; r0_b = 32'h00000007; r0_sel = 5'd0;
    r1_valid = 1'b1; r1_a = p1; r1_b = 32'h89ABCDEF; r1_sel = 5'd0;
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("cont_grant", {r0_ready, r1_ready}, k[0] ? 2'b01 : 2'b10);
      tick();
      #1;
      check("cont_busy", busy, 1'b1);
      tick();
      #1;
      check("cont_rsp_valid", {r0_rsp_valid, r1_rsp_valid}, k[0] ? 2'b01 : 2'b10);
      check("cont_rsp_f", rsp_f, k[0] ? 32'h8ACF1356 : 32'h0000000C);
      tick();
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;
    tick();

    // Backpressure on r1's response while r0 waits
    r1_valid = 1'b1; r1_a = 32'h12345678; r1_b = 32'h0F0F0F0F; r1_sel = 5'd3;
    #1;
    check("bp_r1_ready", r1_ready, 1'b1);
    tick();
    r1_valid = 1'b0;
    r0_valid = 1'b1; r0_a = 32'h00000010; r0_b = 32'h00000020; r0_sel = 5'd0;
    r0_rsp_ready = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_rsp_f", rsp_f, 32'h1F3F5F7F);
      check("bp_r0_ready", r0_ready, 1'b0);
      check("bp_busy", busy, 1'b1);
      check("bp_rsp_valid", {r0_rsp_valid, r1_rsp_valid}, 2'b01);
      tick();
    end
    r1_rsp_ready = 1'b1;
    tick();
    r1_rsp_ready = 1'b0;
    #1;
    check("bp_release_busy", busy, 1'b0);
    check("bp_release_rsp", r1_rsp_valid, 1'b0);
    check("bp_r0_now_ready", r0_ready, 1'b1);
    tick();
    r0_valid = 1'b0;
    tick();
    #1;
    check("bp_r0_rsp", {r0_rsp_valid, rsp_f}, {1'b1, 32'h00000030});
    tick();
    r0_rsp_ready = 1'b0;

    // Random traffic against the transaction-level model
    reset_dut();
    m_busy = 1'b0; m_last = 1'b1; m_owner = 1'b0; m_wait = 0; m_exp = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (!r0_valid && ($urandom_range(1, 0) == 1)) begin
        r0_valid = 1'b1; r0_a = $urandom; r0_b = $urandom; r0_sel = 5'($urandom);
      end
      if (!r1_valid && ($urandom_range(1, 0) == 1)) begin
        r1_valid = 1'b1; r1_a = $urandom; r1_b = $urandom; r1_sel = 5'($urandom);
      end
      r0_rsp_ready = ($urandom_range(2, 0) != 0);
      r1_rsp_ready = ($urandom_range(2, 0) != 0);
      #1;
      win = (r0_valid && r1_valid) ? !m_last : r1_valid;
      e0 = !m_busy && r0_valid && !win;
      e1 = !m_busy && r1_valid && win;
      check("rnd_ready", {r0_ready, r1_ready}, {e0, e1});
      check("rnd_busy", busy, m_busy);
      check("rnd_rsp_valid", {r0_rsp_valid, r1_rsp_valid},
            (m_busy && m_wait == 0) ? (m_owner ? 2'b01 : 2'b10) : 2'b00);
      if (m_busy && m_wait == 0) check("rnd_rsp_fz", {rsp_z, rsp_f}, m_exp);
      acc0 = e0; acc1 = e1;
      if (!m_busy) begin
        if (e0 || e1) begin
          m_busy = 1'b1; m_owner = win; m_wait = 1;
          m_exp = win ? alu_fn(r1_a, r1_b, r1_sel) : alu_fn(r0_a, r0_b, r0_sel);
        end
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (m_owner ? r1_rsp_ready : r0_rsp_ready) begin
        m_busy = 1'b0; m_last = m_owner;
      end
      tick();
      if (acc0) r0_valid = 1'b0;
      if (acc1) r1_valid = 1'b0;
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;

    // EXEC_CYCLES=3: abort in EXEC, then a fresh op
    c_rst = 1'b1;
    tick();
    c_rst = 1'b0;
    c_r0_valid = 1'b1; c_r0_a = 32'h0000BEEF; c_r0_b = 32'h00000001; c_r0_sel = 5'd0;
    #1;
    check("x3_ready", {c_r0_ready, c_r1_ready}, 2'b10);
    tick();
    c_r0_valid = 1'b0;
    c_r0_rsp_ready = 1'b1;
    tick();
    c_rst = 1'b1;
    tick();
    c_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("x3_abort_no_rsp", {c_r0_rsp_valid, c_r1_rsp_valid, c_busy}, 3'b000);
      tick();
    end
    c_r0_rsp_ready = 1'b0;
    a2 = 32'hCAFE0001;
    c_r0_valid = 1'b1; c_r0_a = a2; c_r0_b = 32'h00000010; c_r0_sel = 5'd4;
    r = alu_fn(a2, 32'h00000010, 5'd4);
    #1;
    check("x3_fresh_ready", c_r0_ready, 1'b1);
    tick();
    c_r0_valid = 1'b0;
    c_r0_a = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("x3_exec_no_rsp", c_r0_rsp_valid, 1'b0);
      check("x3_alu_a_stable", c_alu_a, a2);
      tick();
    end
    #1;
    check("x3_rsp_valid", c_r0_rsp_valid, 1'b1);
    check("x3_rsp_fz", {c_rsp_z, c_rsp_f}, r);
    c_r0_rsp_ready = 1'b1;
    tick();
    #1;
    check("x3_idle_after", c_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
